// File: rtl/sfu_ctrl.sv
// Sequencer that streams output-FIFO partial sums into the SFU accumulators,
// one channel per read, then requests the ReLU'd send-out for the pass.
`timescale 1ns/1ps
module sfu_ctrl #(
  parameter int unsigned psum_bw   = 16,
  parameter int unsigned input_ch  = 16,
  parameter int unsigned num_iters = 4,
  localparam int unsigned CH_W     = (input_ch > 1) ? $clog2(input_ch) : 1,
  localparam int unsigned IT_W     = (num_iters > 1) ? $clog2(num_iters) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ofifo_valid,
  input  logic [psum_bw-1:0] ofifo_data,
  output logic               ofifo_rd,
  output logic               sfu_clr,
  output logic [psum_bw-1:0] sfu_psum,
  output logic               sfu_valid,
  output logic [CH_W-1:0]    sfu_ch,
  output logic               sfu_send_out,
  output logic               busy,
  output logic               done
);

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(input_ch - 1);
  localparam logic [IT_W-1:0] IT_LAST = IT_W'(num_iters - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_DRAIN,
    S_SEND,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_cnt_q, ch_cnt_d;
  logic [IT_W-1:0]    iter_cnt_q, iter_cnt_d;
  logic [psum_bw-1:0] sfu_psum_q, sfu_psum_d;
  logic [CH_W-1:0]    sfu_ch_q, sfu_ch_d;
  logic               sfu_valid_q, sfu_valid_d;
  logic               sfu_clr_q, sfu_clr_d;
  logic               send_q, send_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd;
  logic               last_rd;

  // Pop is combinational so a stalled FIFO never costs an extra cycle.
  assign rd       = (state_q == S_ACCUM) && ofifo_valid;
  assign ofifo_rd = rd;

  always_comb begin
    state_d     = state_q;
    ch_cnt_d    = ch_cnt_q;
    iter_cnt_d  = iter_cnt_q;
    sfu_psum_d  = sfu_psum_q;
    sfu_ch_d    = sfu_ch_q;
    sfu_valid_d = rd;
    last_rd     = rd && (ch_cnt_q == CH_LAST) && (iter_cnt_q == IT_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        ch_cnt_d   = '0;
        iter_cnt_d = '0;
        state_d    = S_ACCUM;
      end
      S_ACCUM: begin
        if (rd) begin
          sfu_psum_d = ofifo_data;
          sfu_ch_d   = ch_cnt_q;
          if (ch_cnt_q == CH_LAST) begin
            ch_cnt_d   = '0;
            iter_cnt_d = iter_cnt_q + IT_W'(1);
          end else begin
            ch_cnt_d = ch_cnt_q + CH_W'(1);
          end
          if (last_rd) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_SEND;
      S_SEND:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status flags are decoded from the next state so they align with it.
    sfu_clr_d = (state_d == S_CLEAR);
    send_d    = (state_d == S_SEND);
    done_d    = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ch_cnt_q    <= '0;
      iter_cnt_q  <= '0;
      sfu_psum_q  <= '0;
      sfu_ch_q    <= '0;
      sfu_valid_q <= 1'b0;
      sfu_clr_q   <= 1'b0;
      send_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_cnt_q    <= ch_cnt_d;
      iter_cnt_q  <= iter_cnt_d;
      sfu_psum_q  <= sfu_psum_d;
      sfu_ch_q    <= sfu_ch_d;
      sfu_valid_q <= sfu_valid_d;
      sfu_clr_q   <= sfu_clr_d;
      send_q      <= send_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sfu_psum     = sfu_psum_q;
  assign sfu_ch       = sfu_ch_q;
  assign sfu_valid    = sfu_valid_q;
  assign sfu_clr      = sfu_clr_q;
  assign sfu_send_out = send_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sfu_ctrl.sv
// Directed bench for sfu_ctrl: FIFO model, per-beat scoreboard and pass timing checks.
`timescale 1ns/1ps
module tb_sfu_ctrl;

  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned IN_CH   = 16;
  localparam int unsigned N_IT    = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               ofifo_valid;
  logic [PSUM_BW-1:0] ofifo_data;
  logic               ofifo_rd;
  logic               sfu_clr;
  logic [PSUM_BW-1:0] sfu_psum;
  logic               sfu_valid;
  logic [3:0]         sfu_ch;
  logic               sfu_send_out;
  logic               busy;
  logic               done;

  sfu_ctrl #(
    .psum_bw  (PSUM_BW),
    .input_ch (IN_CH),
    .num_iters(N_IT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .ofifo_data  (ofifo_data),
    .ofifo_rd    (ofifo_rd),
    .sfu_clr     (sfu_clr),
    .sfu_psum    (sfu_psum),
    .sfu_valid   (sfu_valid),
    .sfu_ch      (sfu_ch),
    .sfu_send_out(sfu_send_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // FIFO model and per-pass statistics
  logic [PSUM_BW-1:0] fifo[$];
  logic [PSUM_BW-1:0] sb_psum[$];
  int                 sb_ch[$];
  int fed, stall_at, stall_left, cyc, t0;
  int rd_cnt, val_cnt, clr_cnt, send_cnt, done_cnt, busy_cnt, neg_cnt;
  int first_rd, last_rd, first_val, last_val, clr_cyc, send_cyc, done_cyc, busy_first, busy_last;
  logic [PSUM_BW-1:0] last_psum;

  task automatic clear_stats();
    rd_cnt = 0; val_cnt = 0; clr_cnt = 0; send_cnt = 0; done_cnt = 0; busy_cnt = 0; neg_cnt = 0;
    first_rd = -1; last_rd = -1; first_val = -1; last_val = -1; clr_cyc = -1;
    send_cyc = -1; done_cyc = -1; busy_first = -1; busy_last = -1;
    last_psum = '0; fed = 0;
    sb_psum.delete();
    sb_ch.delete();
  endtask

  task automatic monitor();
    if (reset) begin
      sb_psum.delete();
      sb_ch.delete();
    end else begin
      if (sfu_valid) begin
        check("sb_nonempty", 32'(sb_psum.size() != 0), 1);
        if (sb_psum.size() != 0) begin
          check("sfu_psum", 32'(sfu_psum), 32'(sb_psum.pop_front()));
          check("sfu_ch", 32'(sfu_ch), sb_ch.pop_front());
        end
        val_cnt++;
        if (first_val < 0) first_val = cyc;
        last_val  = cyc;
        last_psum = sfu_psum;
        if (sfu_psum == 16'hFF9C) neg_cnt++;
      end
      if (ofifo_rd) begin
        sb_psum.push_back(ofifo_data);
        sb_ch.push_back(rd_cnt % IN_CH);
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (sfu_clr) begin clr_cnt++; clr_cyc = cyc; end
      if (sfu_send_out) begin send_cnt++; send_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
    end
  endtask

  task automatic drive_fifo();
    if (stall_left > 0) begin
      ofifo_valid = 1'b0;
      stall_left--;
    end else begin
      ofifo_valid = (fifo.size() > 0);
    end
    ofifo_data = (fifo.size() > 0) ? fifo[0] : '0;
  endtask

  // One clock: observe at negedge, then update stimulus 1ns after posedge.
  task automatic cycle();
    logic pop_now;
    @(negedge clk);
    monitor();
    pop_now = ofifo_rd & ~reset;
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    if (pop_now) begin
      fifo.delete(0);
      fed++;
      if (fed == stall_at) stall_left = 5;
    end
    drive_fifo();
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) fifo.push_back(PSUM_BW'(base + i));
    drive_fifo();
  endtask

  task automatic begin_pass();
    clear_stats();
    start = 1'b1;
    t0    = cyc;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      cycle();
      k++;
    end
    check("done_within_budget", 32'(done_cnt > 0), 1);
    repeat (4) cycle();
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_ofifo_rd"}, 32'(ofifo_rd), 0);
    check({tag, "_sfu_clr"}, 32'(sfu_clr), 0);
    check({tag, "_sfu_psum"}, 32'(sfu_psum), 0);
    check({tag, "_sfu_valid"}, 32'(sfu_valid), 0);
    check({tag, "_sfu_ch"}, 32'(sfu_ch), 0);
    check({tag, "_send_out"}, 32'(sfu_send_out), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0; ofifo_data = '0;
    cyc = 0; stall_at = -1; stall_left = 0;
    clear_stats();
    repeat (3) cycle();
    check_zero_outs("rst");
    reset = 1'b0;
    cycle();

    // Continuous stream of 0..63: timing and channel order
    load(64, 0);
    begin_pass();
    wait_done(200);
    check("t1_clr_cyc", clr_cyc - t0, 1);
    check("t1_clr_cnt", clr_cnt, 1);
    check("t1_first_rd", first_rd - t0, 2);
    check("t1_last_rd", last_rd - t0, 65);
    check("t1_rd_cnt", rd_cnt, 64);
    check("t1_first_val", first_val - t0, 3);
    check("t1_last_val", last_val - t0, 66);
    check("t1_val_cnt", val_cnt, 64);
    check("t1_last_psum", 32'(last_psum), 63);
    check("t1_send_cyc", send_cyc - t0, 67);
    check("t1_send_cnt", send_cnt, 1);
    check("t1_done_cyc", done_cyc - t0, 68);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_busy_first", busy_first - t0, 1);
    check("t1_busy_last", busy_last - t0, 68);
    check("t1_busy_cnt", busy_cnt, 68);

    // Five-cycle stall after the 20th read
    load(64, 1000);
    begin_pass();
    stall_at = 20;
    wait_done(200);
    stall_at = -1;
    check("t2_rd_cnt", rd_cnt, 64);
    check("t2_val_cnt", val_cnt, 64);
    check("t2_val_gap", (last_val - first_val + 1) - val_cnt, 5);
    check("t2_last_rd", last_rd - t0, 70);
    check("t2_send_cyc", send_cyc - t0, 72);
    check("t2_done_cyc", done_cyc - t0, 73);
    check("t2_done_cnt", done_cnt, 1);

    // Overfeed with negative psums at 61..63
    load(70, 0);
    for (int i = 61; i < 64; i++) fifo[i] = 16'hFF9C;
    drive_fifo();
    begin_pass();
    wait_done(200);
    check("t3_rd_cnt", rd_cnt, 64);
    check("t3_fifo_left", fifo.size(), 6);
    check("t3_neg_cnt", neg_cnt, 3);
    check("t3_last_psum", 32'(last_psum), 32'h0000_FF9C);
    check("t3_done_cnt", done_cnt, 1);
    fifo.delete();
    drive_fifo();

    // Reset mid-ACCUM after 30 reads, then a fresh pass
    load(30, 500);
    begin_pass();
    for (int k = 0; k < 200 && fed < 30; k++) cycle();
    repeat (2) cycle();
    check("t4_rd_before_rst", rd_cnt, 30);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    load(64, 300);
    check_zero_outs("t4_after_rst");
    repeat (3) cycle();
    check("t4_abort_rd", rd_cnt, 30);
    check("t4_abort_send", send_cnt, 0);
    check("t4_abort_done", done_cnt, 0);
    begin_pass();
    wait_done(200);
    check("t4_clr_cyc", clr_cyc - t0, 1);
    check("t4_rd_cnt", rd_cnt, 64);
    check("t4_send_cyc", send_cyc - t0, 67);
    check("t4_done_cnt", done_cnt, 1);

    // start pulses during ACCUM and SEND must not restart the pass
    load(64, 2000);
    begin_pass();
    for (int k = 0; k < 200 && done_cnt == 0; k++) begin
      cycle();
      if (cyc - t0 == 10 || cyc - t0 == 67) start = 1'b1;
    end
    repeat (8) cycle();
    check("t5_clr_cnt", clr_cnt, 1);
    check("t5_rd_cnt", rd_cnt, 64);
    check("t5_send_cyc", send_cyc - t0, 67);
    check("t5_done_cnt", done_cnt, 1);
    check("t5_busy_last", busy_last - t0, 68);
    check("t5_busy_cnt", busy_cnt, 68);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
